// File: rtl/xoodyak_pkg.sv
// Shared opmode/state types for the Xoodyak command sequencer.
// op_has_output flags ops whose textout is returned to the host.
package xoodyak_pkg;

  typedef enum logic [2:0] {
    OP_IDLE    = 3'd0,
    OP_INIT    = 3'd1,
    OP_NONCE   = 3'd2,
    OP_ASSOC   = 3'd3,
    OP_CRYPT   = 3'd4,
    OP_DECRYPT = 3'd5,
    OP_SQUEEZE = 3'd6,
    OP_RATCHET = 3'd7
  } op_e;

  localparam int OP_CONT_BIT = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESULT,
    ST_FLUSH
  } state_e;

  function automatic logic op_has_output(input logic [5:0] op);
    return (op[2:0] == OP_CRYPT) ||
           (op[2:0] == OP_DECRYPT) ||
           (op[2:0] == OP_SQUEEZE);
  endfunction

endpackage

// File: rtl/xoodyak_cmd_fifo.sv
// Register-based command FIFO with push/pop/flush and occupancy count.
// Storage has no reset; only pointers and count are cleared.
module xoodyak_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 358,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/xoodyak_op_sequencer.sv
// Issues queued opmode/data commands to the Xoodyak core one at a time,
// waits for finished with a timeout, and returns output text to the host.
module xoodyak_op_sequencer
  import xoodyak_pkg::*;
#(
  parameter int DATA_W  = 352,
  parameter int TEXT_W  = 192,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              eph1,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [5:0]        cmd_opmode,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              core_start,
  output logic [5:0]        core_opmode,
  output logic [DATA_W-1:0] core_data,
  input  logic              core_finished,
  input  logic [TEXT_W-1:0] core_textout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [TEXT_W-1:0] res_data,
  output logic [5:0]        res_opmode,
  output logic              busy,
  output logic [CNT_W-1:0]  q_count,
  output logic [1:0]        err,
  input  logic              err_clr
);

  localparam int FW = 6 + DATA_W;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e            state_q;
  logic              core_start_q;
  logic [5:0]        core_opmode_q;
  logic [DATA_W-1:0] core_data_q;
  logic              res_valid_q;
  logic [TEXT_W-1:0] res_data_q;
  logic [5:0]        res_opmode_q;
  logic [TW-1:0]     tmo_q;
  logic [1:0]        err_q;
  logic [1:0]        err_d;

  logic [FW-1:0]     head;
  logic [5:0]        head_op;
  logic [DATA_W-1:0] head_data;
  logic              push;
  logic              pop;
  logic              flush;
  logic              tmo_hit;

  assign head_op   = head[FW-1:DATA_W];
  assign head_data = head[DATA_W-1:0];

  assign cmd_ready = (q_count < CNT_W'(DEPTH)) &&
                     (state_q != ST_FLUSH);
  assign push  = cmd_valid && cmd_ready;
  assign pop   = (state_q == ST_IDLE) && (q_count != '0);
  assign flush = (state_q == ST_FLUSH);

  assign tmo_hit = (TIMEOUT != 0) &&
                   (tmo_q == TW'(TIMEOUT - 1));

  // A finish arriving with the timeout takes priority over the error.
  assign err_d = (err_q & ~{2{err_clr}}) |
                 {core_finished && (state_q != ST_WAIT),
                  (state_q == ST_WAIT) && !core_finished && tmo_hit};

  xoodyak_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FW),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (eph1),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i ({cmd_opmode, cmd_data}),
    .rdata_o (head),
    .count_o (q_count)
  );

  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      core_start_q  <= 1'b0;
      core_opmode_q <= '0;
      core_data_q   <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_opmode_q  <= '0;
      tmo_q         <= '0;
      err_q         <= '0;
    end else begin
      core_start_q <= 1'b0;
      err_q        <= err_d;
      unique case (state_q)
        ST_IDLE: begin
          if (pop && (head_op[2:0] != OP_IDLE)) begin
            core_opmode_q <= head_op;
            core_data_q   <= head_data;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          core_start_q <= 1'b1;
          tmo_q        <= '0;
          state_q      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_finished) begin
            if (op_has_output(core_opmode_q)) begin
              res_valid_q  <= 1'b1;
              res_data_q   <= core_textout;
              res_opmode_q <= core_opmode_q;
              state_q      <= ST_RESULT;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (tmo_hit) begin
            state_q <= ST_FLUSH;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          core_opmode_q <= '0;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core_start  = core_start_q;
  assign core_opmode = core_opmode_q;
  assign core_data   = core_data_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_opmode  = res_opmode_q;
  assign err         = err_q;
  assign busy        = (state_q != ST_IDLE) || (q_count != '0);

endmodule

// File: tb/tb_xoodyak_op_sequencer.sv
// Directed + randomized bench for xoodyak_op_sequencer with a
// behavioural core model and in-order issue/result scoreboard.
module tb_xoodyak_op_sequencer;

  localparam int DATA_W  = 352;
  localparam int TEXT_W  = 192;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PER     = 10;

  logic              eph1;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [5:0]        cmd_opmode;
  logic [DATA_W-1:0] cmd_data;
  logic              core_start;
  logic [5:0]        core_opmode;
  logic [DATA_W-1:0] core_data;
  logic              core_finished;
  logic [TEXT_W-1:0] core_textout;
  logic              res_valid;
  logic              res_ready;
  logic [TEXT_W-1:0] res_data;
  logic [5:0]        res_opmode;
  logic              busy;
  logic [CNT_W-1:0]  q_count;
  logic [1:0]        err;
  logic              err_clr;

  xoodyak_op_sequencer #(
    .DATA_W  (DATA_W),
    .TEXT_W  (TEXT_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .eph1          (eph1),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_opmode    (cmd_opmode),
    .cmd_data      (cmd_data),
    .core_start    (core_start),
    .core_opmode   (core_opmode),
    .core_data     (core_data),
    .core_finished (core_finished),
    .core_textout  (core_textout),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_opmode    (res_opmode),
    .busy          (busy),
    .q_count       (q_count),
    .err           (err),
    .err_clr       (err_clr)
  );

  initial eph1 = 1'b0;
  always #(PER / 2) eph1 = ~eph1;

  int  checks;
  int  errors;
  int  starts;
  int  res_cnt;
  time start_t;

  logic [DATA_W+5:0] exp_issue [$];
  logic [TEXT_W+5:0] exp_res [$];

  // Core model state
  logic              model_fin;
  logic              spur_fin;
  int                cd;
  int                fixed_lat;
  bit                stall;
  logic [5:0]        lop;
  logic [DATA_W-1:0] ldat;
  logic              man_rdy;
  logic              rr_rand;
  bit                auto_rdy;

  assign core_finished = model_fin | spur_fin;
  assign res_ready     = auto_rdy ? rr_rand : man_rdy;

  function automatic logic [TEXT_W-1:0] text_f(
    input logic [5:0] op, input logic [DATA_W-1:0] d);
    return d[TEXT_W-1:0] ^ {32{op}} ^ {6{32'h5a3c_96e1}};
  endfunction

  function automatic bit has_out(input logic [5:0] op);
    return (op[2:0] == 3'd4) || (op[2:0] == 3'd5) ||
           (op[2:0] == 3'd6);
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] seq_data(input logic [7:0] s);
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 8; i++)
      v[DATA_W-1-i*8 -: 8] = s + 8'(i);
    return v;
  endfunction

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic tick();
    @(posedge eph1);
    #1;
  endtask

  task automatic push(input logic [5:0] op,
                      input logic [DATA_W-1:0] d);
    bit ok;
    bit r;
    ok = 0;
    cmd_valid  = 1'b1;
    cmd_opmode = op;
    cmd_data   = d;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge eph1);
      r = cmd_ready;
      tick();
      ok = r;
    end
    cmd_valid = 1'b0;
    if (ok) begin
      if (op[2:0] != 3'd0) exp_issue.push_back({op, d});
    end else begin
      bound_fail("push_accept");
    end
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge eph1);
      ok = !busy && !res_valid && (exp_issue.size() == 0) &&
           (exp_res.size() == 0);
    end
    if (!ok) bound_fail(tag);
    tick();
  endtask

  task automatic wait_res_valid(input string tag, input int maxc);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge eph1);
      ok = res_valid;
    end
    if (!ok) bound_fail(tag);
  endtask

  task automatic wait_start(input string tag, input int maxc);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge eph1);
      ok = core_start;
    end
    if (!ok) bound_fail(tag);
  endtask

  // Core: finishes a fixed or random number of cycles after start.
  always @(posedge eph1) begin
    #1;
    model_fin = 1'b0;
    rr_rand   = 1'($urandom_range(0, 1));
    if (reset) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0 && !stall) begin
          model_fin    = 1'b1;
          core_textout = text_f(lop, ldat);
        end
      end
      if (core_start) begin
        lop  = core_opmode;
        ldat = core_data;
        cd   = (fixed_lat > 0) ? fixed_lat
                               : int'($urandom_range(1, 12));
      end
    end
  end

  // Scoreboard: issue order and results against pushed commands.
  always @(negedge eph1) begin
    logic [DATA_W+5:0] me;
    logic [TEXT_W+5:0] mr;
    if (!reset) begin
      if (core_start) begin
        starts++;
        start_t = $time;
        if (exp_issue.size() == 0) begin
          bound_fail("issue_unexpected");
        end else begin
          me = exp_issue.pop_front();
          chk("issue_op", 512'(core_opmode), 512'(me[DATA_W+5:DATA_W]));
          chk("issue_data", 512'(core_data), 512'(me[DATA_W-1:0]));
          if (has_out(me[DATA_W+5:DATA_W]))
            exp_res.push_back({me[DATA_W+5:DATA_W],
                               text_f(me[DATA_W+5:DATA_W],
                                      me[DATA_W-1:0])});
        end
      end
      if (res_valid && res_ready) begin
        res_cnt++;
        if (exp_res.size() == 0) begin
          bound_fail("result_unexpected");
        end else begin
          mr = exp_res.pop_front();
          chk("res_opmode", 512'(res_opmode), 512'(mr[TEXT_W+5:TEXT_W]));
          chk("res_data", 512'(res_data), 512'(mr[TEXT_W-1:0]));
        end
      end
    end
  end

  initial begin
    #(PER * 60000);
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int r;
    int ns;
    int nr;
    time t_err;
    bit ok;
    logic [5:0] op;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] d9;
    int ops [8];

    checks = 0; errors = 0; starts = 0; res_cnt = 0; start_t = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_opmode = '0; cmd_data = '0;
    spur_fin = 1'b0; err_clr = 1'b0; man_rdy = 1'b1; auto_rdy = 0;
    stall = 0; fixed_lat = 12; cd = 0; model_fin = 1'b0;
    core_textout = '0; rr_rand = 1'b0;

    repeat (3) @(posedge eph1);
    @(negedge eph1);
    chk("rst_cmd_ready", 512'(cmd_ready), 512'(1));
    chk("rst_core_start", 512'(core_start), 512'(0));
    chk("rst_core_opmode", 512'(core_opmode), 512'(0));
    chk("rst_core_data", 512'(core_data), 512'(0));
    chk("rst_res_valid", 512'(res_valid), 512'(0));
    chk("rst_res_data", 512'(res_data), 512'(0));
    chk("rst_res_opmode", 512'(res_opmode), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_q_count", 512'(q_count), 512'(0));
    chk("rst_err", 512'(err), 512'(0));
    tick();
    reset = 1'b0;

    // Init/nonce/assoc/crypt sequence, first-start latency
    push(6'h01, seq_data(8'h38));
    @(negedge eph1);
    chk("lat0_start", 512'(core_start), 512'(0));
    chk("lat0_count", 512'(q_count), 512'(1));
    @(negedge eph1);
    chk("lat1_start", 512'(core_start), 512'(0));
    chk("lat1_busy", 512'(busy), 512'(1));
    @(negedge eph1);
    chk("lat2_start", 512'(core_start), 512'(1));
    tick();
    push(6'h02, rnd_data());
    push(6'h03, rnd_data());
    push(6'h04, seq_data(8'h4d));
    wait_idle("t1_idle", 600);
    chk("t1_starts", 512'(starts), 512'(4));
    chk("t1_results", 512'(res_cnt), 512'(1));
    chk("t1_err", 512'(err), 512'(0));

    // Fill FIFO while a result is held; 9th push waits for a pop
    s = starts; r = res_cnt;
    fixed_lat = 4;
    man_rdy = 1'b0;
    push(6'h06, rnd_data());
    wait_res_valid("t2_res_valid", 60);
    tick();
    ops = '{3, 4, 1, 2, 5, 6, 7, 3};
    foreach (ops[i]) push(6'(ops[i]), rnd_data());
    @(negedge eph1);
    chk("t2_full_count", 512'(q_count), 512'(8));
    chk("t2_full_ready", 512'(cmd_ready), 512'(0));
    tick();
    d9 = rnd_data();
    cmd_valid = 1'b1; cmd_opmode = 6'h03; cmd_data = d9;
    repeat (3) begin
      @(negedge eph1);
      chk("t2_hold_ready", 512'(cmd_ready), 512'(0));
    end
    chk("t2_hold_count", 512'(q_count), 512'(8));
    tick();
    man_rdy = 1'b1;
    push(6'h03, d9);
    @(negedge eph1);
    chk("t2_after_count", 512'(q_count), 512'(8));
    tick();
    wait_idle("t2_idle", 1000);
    chk("t2_starts", 512'(starts), 512'(s + 10));
    chk("t2_results", 512'(res_cnt), 512'(r + 4));

    // Squeeze result held 5 cycles with res_ready low
    s = starts;
    fixed_lat = 3;
    man_rdy = 1'b0;
    d = rnd_data();
    push(6'h26, d);
    push(6'h03, rnd_data());
    wait_res_valid("t4_res_valid", 60);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge eph1);
      chk("t4_hold_valid", 512'(res_valid), 512'(1));
      chk("t4_hold_data", 512'(res_data), 512'(text_f(6'h26, d)));
      chk("t4_hold_op", 512'(res_opmode), 512'(6'h26));
      chk("t4_no_start", 512'(starts), 512'(s + 1));
    end
    tick();
    man_rdy = 1'b1;
    wait_start("t4_next_start", 30);
    tick();
    chk("t4_next_starts", 512'(starts), 512'(s + 2));
    wait_idle("t4_idle", 200);

    // Idle opmode discarded; spurious finished and err_clr
    s = starts;
    fixed_lat = 2;
    push(6'h03, rnd_data());
    push(6'h20, rnd_data());
    push(6'h03, rnd_data());
    wait_idle("t5_idle", 200);
    chk("t5_starts", 512'(starts), 512'(s + 2));
    spur_fin = 1'b1;
    tick();
    spur_fin = 1'b0;
    @(negedge eph1);
    chk("t5_spur_err", 512'(err), 512'(2'b10));
    tick();
    err_clr = 1'b1; spur_fin = 1'b1;
    tick();
    err_clr = 1'b0; spur_fin = 1'b0;
    @(negedge eph1);
    chk("t5_set_wins", 512'(err), 512'(2'b10));
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge eph1);
    chk("t5_cleared", 512'(err), 512'(2'b00));
    tick();

    // Timeout with three queued commands flushed
    stall = 1;
    fixed_lat = 4;
    push(6'h03, rnd_data());
    push(6'h04, rnd_data());
    push(6'h01, rnd_data());
    push(6'h06, rnd_data());
    ok = 0; t_err = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge eph1);
      if (err != 2'b00) begin
        ok = 1;
        t_err = $time;
      end
    end
    if (!ok) bound_fail("t3_err_wait");
    chk("t3_err", 512'(err), 512'(2'b01));
    chk("t3_delay", 512'((t_err - start_t) / PER), 512'(TIMEOUT));
    chk("t3_queued", 512'(q_count), 512'(3));
    @(negedge eph1);
    chk("t3_flush_count", 512'(q_count), 512'(0));
    chk("t3_flush_busy", 512'(busy), 512'(0));
    chk("t3_flush_op", 512'(core_opmode), 512'(0));
    exp_issue.delete();
    stall = 0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge eph1);
    chk("t3_err_clr", 512'(err), 512'(0));
    tick();

    // Asynchronous reset while core_start is high
    stall = 1;
    push(6'h01, rnd_data());
    wait_start("t6_start", 20);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_core_start", 512'(core_start), 512'(0));
    chk("t6_busy", 512'(busy), 512'(0));
    chk("t6_q_count", 512'(q_count), 512'(0));
    chk("t6_core_opmode", 512'(core_opmode), 512'(0));
    chk("t6_core_data", 512'(core_data), 512'(0));
    chk("t6_cmd_ready", 512'(cmd_ready), 512'(1));
    exp_issue.delete();
    exp_res.delete();
    @(posedge eph1);
    tick();
    reset = 1'b0;
    stall = 0;
    fixed_lat = 5;
    s = starts;
    push(6'h01, rnd_data());
    wait_idle("t6_idle", 200);
    chk("t6_restart", 512'(starts), 512'(s + 1));
    chk("t6_err", 512'(err), 512'(0));

    // Random command mix with random latency and res_ready
    auto_rdy = 1;
    fixed_lat = 0;
    s = starts; r = res_cnt; ns = 0; nr = 0;
    for (int i = 0; i < 40; i++) begin
      op = {1'($urandom_range(0, 1)), 2'b00, 3'($urandom_range(0, 7))};
      if (op[2:0] != 3'd0) ns++;
      if (has_out(op)) nr++;
      push(op, rnd_data());
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle("rnd_idle", 3000);
    chk("rnd_starts", 512'(starts), 512'(s + ns));
    chk("rnd_results", 512'(res_cnt), 512'(r + nr));
    chk("rnd_err", 512'(err), 512'(0));
    chk("rnd_q_count", 512'(q_count), 512'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
